pilot_extract: RTL and testbench
================================

Name: pilot_extract

Overview:
- Streaming pilot-removal stage for the QAM-16 OFDM receiver, placed between the demodulator symbol stream and the channel estimator/demapper.
- Runs in a single clock domain with valid/ready handshakes on every stream, so it can apply backpressure.
- Accepts frames of FRAME_LEN symbols and splits them into two output streams:
  - the data stream, with pilots removed and SOF/EOF markers regenerated;
  - a pilot stream, each pilot tagged with its index, for channel estimation.
- Supports a bypass mode and resynchronises on a mid-frame SOF.

Parameters:
WIDTH, 16, symbol width in bits (I/Q packed)
FRAME_LEN, 410, input symbols per frame
PILOT_SPACING, 41, symbols between consecutive pilots; FRAME_LEN % PILOT_SPACING must be 0
PILOT_OFFSET, 0, position of the pilot within each spacing period (0..PILOT_SPACING-1)
Derived localparams:
- NUM_PILOTS = FRAME_LEN/PILOT_SPACING
- DATA_LEN = FRAME_LEN - NUM_PILOTS
- IW = clog2(FRAME_LEN)
- PW = clog2(NUM_PILOTS)

Ports:
clk1  in  1  clock
rst_n  in  1  asynchronous reset, active-low
bypass  in  1  1 = forward every symbol to the data stream, no pilot removal; sampled only at frame boundary (idx==0)
in_data  in  WIDTH  input symbol
in_valid  in  1  input symbol valid
in_sof  in  1  first symbol of a frame, qualified by in_valid
in_ready  out  1  input accepted when in_valid&&in_ready
d_data  out  WIDTH  data symbol
d_valid  out  1  data symbol valid
d_sof  out  1  first data symbol of a frame
d_eof  out  1  last data symbol of a frame
d_ready  in  1  downstream accepts data
p_data  out  WIDTH  pilot symbol
p_idx  out  PW  pilot number within frame, 0..NUM_PILOTS-1
p_valid  out  1  pilot valid
p_ready  in  1  estimator accepts pilot
sync_err  out  1  one-cycle pulse on resync
err_cnt  out  8  saturating count of resyncs
frame_cnt  out  16  completed input frames, wraps at 65535->0

Behaviour:
- Reset: all counters 0; d_valid, p_valid, d_sof, d_eof, sync_err = 0; d_data, p_data, p_idx = 0; err_cnt, frame_cnt = 0; latched bypass = 0. Reset mid-frame discards all buffered symbols immediately.
- Internal counters, all advanced only on an input handshake (in_valid&&in_ready):
  - idx: 0..FRAME_LEN-1;
  - sub: 0..PILOT_SPACING-1, wraps to 0 when idx wraps;
  - pcnt: pilots seen this frame;
  - dcnt: data symbols output this frame.
- Classification: a symbol is a pilot when sub==PILOT_OFFSET and bypass_l==0. All other symbols are data.
- Output registers: one holding register per stream, no combinational path from input to output. Latency is 1 cycle, from input handshake to the *_valid assertion.
- in_ready = pilot_slot ? (!p_valid || p_ready) : (!d_valid || d_ready).
  - pilot_slot is a function of counter state only; it does not depend on in_valid.
  - in_ready is therefore held low while the target register is full and not draining.
- Output valid rules:
  - A register with valid=1 holds its contents stable until its ready goes high.
  - Simultaneous drain and refill in one cycle is allowed: valid stays 1 and new data is loaded.
- Marker generation:
  - d_sof = 1 when dcnt==0.
  - d_eof = 1 when dcnt==DATA_LEN-1, or dcnt==FRAME_LEN-1 in bypass.
  - p_idx = pcnt.
- Frame end: on the handshake with idx==FRAME_LEN-1:
  - idx, sub, pcnt and dcnt return to 0;
  - frame_cnt increments;
  - bypass is re-latched.
- SOF handling:
  - Accepted in_sof with idx==0: normal start.
  - Accepted in_sof with idx!=0: the symbol is treated as idx 0 of a new frame. Counters restart from this symbol, sync_err pulses, err_cnt increments and saturates at 255, and frame_cnt does not increment. The partial frame already output is not retracted, and its d_eof is never issued.
  - in_sof is not required: the frame free-runs on the counters.
- Bypass path: pilot stream idle, p_valid stays 0.

Test Plan:
- Reset, then 410 symbols with value=index, sof on 0, both readies held 1 -> 400 data symbols with pilots at 0,41,...,369 removed. First d_data=1 with d_sof; last d_data=409 with d_eof; p_data 0,41,...,369 with p_idx 0..9; frame_cnt=1.
- Same stimulus with d_ready toggling 1-of-3 cycles and p_ready held 0 until idx 100 -> in_ready stalls at idx 41. No symbol is lost or duplicated, data order is preserved, and totals are unchanged.
- in_sof asserted at idx 200 of frame 1 -> sync_err pulses once and err_cnt=1. The next pilot is taken at the new symbol (p_idx=0), frame_cnt is not incremented, and no d_eof is issued for the aborted frame.
- bypass=1 raised mid-frame -> takes effect only at the next frame, which passes 410 symbols with d_eof on the 410th and no p_valid.
- Reset asserted with d_valid=p_valid=1 -> all valids drop immediately; the next frame after release starts at idx 0.
- Parameter set WIDTH=8, FRAME_LEN=64, PILOT_SPACING=8, PILOT_OFFSET=3 -> pilots at 3,11,...,59 (8 of them); 56 data symbols out, d_eof on input symbol 63.

Source files
------------

// File: rtl/pilot_extract.sv
// Streaming pilot removal: splits each frame into a data stream (pilots removed,
// SOF/EOF regenerated) and an indexed pilot stream, with bypass and mid-frame resync.
module pilot_extract #(
  parameter int WIDTH         = 16,
  parameter int FRAME_LEN     = 410,
  parameter int PILOT_SPACING = 41,
  parameter int PILOT_OFFSET  = 0
) (
  input  logic                                      clk1,
  input  logic                                      rst_n,
  input  logic                                      bypass,
  input  logic [WIDTH-1:0]                          in_data,
  input  logic                                      in_valid,
  input  logic                                      in_sof,
  output logic                                      in_ready,
  output logic [WIDTH-1:0]                          d_data,
  output logic                                      d_valid,
  output logic                                      d_sof,
  output logic                                      d_eof,
  input  logic                                      d_ready,
  output logic [WIDTH-1:0]                          p_data,
  output logic [$clog2(FRAME_LEN/PILOT_SPACING)-1:0] p_idx,
  output logic                                      p_valid,
  input  logic                                      p_ready,
  output logic                                      sync_err,
  output logic [7:0]                                err_cnt,
  output logic [15:0]                               frame_cnt
);

  localparam int NUM_PILOTS = FRAME_LEN / PILOT_SPACING;
  localparam int DATA_LEN   = FRAME_LEN - NUM_PILOTS;
  localparam int IW         = $clog2(FRAME_LEN);
  localparam int PW         = $clog2(NUM_PILOTS);

  localparam logic [IW-1:0] LAST_IDX  = IW'(FRAME_LEN - 1);
  localparam logic [IW-1:0] LAST_SUB  = IW'(PILOT_SPACING - 1);
  localparam logic [IW-1:0] PILOT_SUB = IW'(PILOT_OFFSET);
  localparam logic [IW-1:0] LAST_DATA = IW'(DATA_LEN - 1);

  logic [IW-1:0]    idx_q, idx_d, sub_q, sub_d, dcnt_q, dcnt_d;
  logic [PW-1:0]    pcnt_q, pcnt_d;
  logic             bypass_l_q, bypass_l_d;
  logic [WIDTH-1:0] d_data_q, d_data_d, p_data_q, p_data_d;
  logic             d_valid_q, d_valid_d, d_sof_q, d_sof_d, d_eof_q, d_eof_d;
  logic [PW-1:0]    p_idx_q, p_idx_d;
  logic             p_valid_q, p_valid_d;
  logic             sync_err_q, sync_err_d;
  logic [7:0]       err_cnt_q, err_cnt_d;
  logic [15:0]      frame_cnt_q, frame_cnt_d;

  logic             restart, pilot_slot, d_free, p_free, accept;
  logic [IW-1:0]    idx_e, sub_e, dcnt_e;
  logic [PW-1:0]    pcnt_e;

  // A SOF seen mid-frame makes this symbol position 0 of a new frame, so the
  // routing decision is taken from the restarted counters.
  always_comb begin
    restart    = in_sof && (idx_q != '0);
    idx_e      = restart ? '0 : idx_q;
    sub_e      = restart ? '0 : sub_q;
    dcnt_e     = restart ? '0 : dcnt_q;
    pcnt_e     = restart ? '0 : pcnt_q;
    pilot_slot = !bypass_l_q && (sub_e == PILOT_SUB);
    d_free     = !d_valid_q || d_ready;
    p_free     = !p_valid_q || p_ready;
    in_ready   = pilot_slot ? p_free : d_free;
    accept     = in_valid && in_ready;
  end

  always_comb begin
    idx_d       = idx_q;
    sub_d       = sub_q;
    dcnt_d      = dcnt_q;
    pcnt_d      = pcnt_q;
    bypass_l_d  = bypass_l_q;
    d_data_d    = d_data_q;
    d_valid_d   = d_valid_q && !d_ready;
    d_sof_d     = d_sof_q;
    d_eof_d     = d_eof_q;
    p_data_d    = p_data_q;
    p_idx_d     = p_idx_q;
    p_valid_d   = p_valid_q && !p_ready;
    sync_err_d  = 1'b0;
    err_cnt_d   = err_cnt_q;
    frame_cnt_d = frame_cnt_q;

    if (accept) begin
      if (restart) begin
        sync_err_d = 1'b1;
        if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
      end

      if (pilot_slot) begin
        p_data_d  = in_data;
        p_idx_d   = pcnt_e;
        p_valid_d = 1'b1;
        pcnt_d    = pcnt_e + PW'(1);
        dcnt_d    = dcnt_e;
      end else begin
        d_data_d  = in_data;
        d_sof_d   = (dcnt_e == '0);
        d_eof_d   = (dcnt_e == (bypass_l_q ? LAST_IDX : LAST_DATA));
        d_valid_d = 1'b1;
        dcnt_d    = dcnt_e + IW'(1);
        pcnt_d    = pcnt_e;
      end

      if (idx_e == LAST_IDX) begin
        idx_d       = '0;
        sub_d       = '0;
        pcnt_d      = '0;
        dcnt_d      = '0;
        frame_cnt_d = frame_cnt_q + 16'd1;
        bypass_l_d  = bypass;
      end else begin
        idx_d = idx_e + IW'(1);
        sub_d = (sub_e == LAST_SUB) ? '0 : sub_e + IW'(1);
      end
    end
  end

  // Register stage: counters and the two output holding registers
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      idx_q       <= '0;
      sub_q       <= '0;
      dcnt_q      <= '0;
      pcnt_q      <= '0;
      bypass_l_q  <= 1'b0;
      d_data_q    <= '0;
      d_valid_q   <= 1'b0;
      d_sof_q     <= 1'b0;
      d_eof_q     <= 1'b0;
      p_data_q    <= '0;
      p_idx_q     <= '0;
      p_valid_q   <= 1'b0;
      sync_err_q  <= 1'b0;
      err_cnt_q   <= '0;
      frame_cnt_q <= '0;
    end else begin
      idx_q       <= idx_d;
      sub_q       <= sub_d;
      dcnt_q      <= dcnt_d;
      pcnt_q      <= pcnt_d;
      bypass_l_q  <= bypass_l_d;
      d_data_q    <= d_data_d;
      d_valid_q   <= d_valid_d;
      d_sof_q     <= d_sof_d;
      d_eof_q     <= d_eof_d;
      p_data_q    <= p_data_d;
      p_idx_q     <= p_idx_d;
      p_valid_q   <= p_valid_d;
      sync_err_q  <= sync_err_d;
      err_cnt_q   <= err_cnt_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign d_data    = d_data_q;
  assign d_valid   = d_valid_q;
  assign d_sof     = d_sof_q;
  assign d_eof     = d_eof_q;
  assign p_data    = p_data_q;
  assign p_idx     = p_idx_q;
  assign p_valid   = p_valid_q;
  assign sync_err  = sync_err_q;
  assign err_cnt   = err_cnt_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_pilot_extract.sv
// Directed scoreboard bench for pilot_extract: default frame geometry plus a
// small 64-symbol geometry instance.
module tb_pilot_extract;

  localparam int FL = 410, SP = 41, OFF = 0, DL = 400;

  logic clk1 = 1'b0;
  always #5 clk1 = ~clk1;

  logic        rst_n, bypass, in_valid, in_sof, in_ready;
  logic [15:0] in_data, d_data, p_data;
  logic        d_valid, d_sof, d_eof, d_ready, p_valid, p_ready, sync_err;
  logic [3:0]  p_idx;
  logic [7:0]  err_cnt;
  logic [15:0] frame_cnt;

  logic        s_bypass, s_in_valid, s_in_sof, s_in_ready;
  logic [7:0]  s_in_data, s_d_data, s_p_data;
  logic        s_d_valid, s_d_sof, s_d_eof, s_d_ready, s_p_valid, s_p_ready, s_sync_err;
  logic [2:0]  s_p_idx;
  logic [7:0]  s_err_cnt;
  logic [15:0] s_frame_cnt;

  pilot_extract u0 (
    .clk1(clk1), .rst_n(rst_n), .bypass(bypass), .in_data(in_data), .in_valid(in_valid),
    .in_sof(in_sof), .in_ready(in_ready), .d_data(d_data), .d_valid(d_valid), .d_sof(d_sof),
    .d_eof(d_eof), .d_ready(d_ready), .p_data(p_data), .p_idx(p_idx), .p_valid(p_valid),
    .p_ready(p_ready), .sync_err(sync_err), .err_cnt(err_cnt), .frame_cnt(frame_cnt)
  );

  pilot_extract #(.WIDTH(8), .FRAME_LEN(64), .PILOT_SPACING(8), .PILOT_OFFSET(3)) u1 (
    .clk1(clk1), .rst_n(rst_n), .bypass(s_bypass), .in_data(s_in_data), .in_valid(s_in_valid),
    .in_sof(s_in_sof), .in_ready(s_in_ready), .d_data(s_d_data), .d_valid(s_d_valid),
    .d_sof(s_d_sof), .d_eof(s_d_eof), .d_ready(s_d_ready), .p_data(s_p_data), .p_idx(s_p_idx),
    .p_valid(s_p_valid), .p_ready(s_p_ready), .sync_err(s_sync_err), .err_cnt(s_err_cnt),
    .frame_cnt(s_frame_cnt)
  );

  int checks = 0, errors = 0;
  logic [31:0] dq[$], pq[$], sdq[$], spq[$];
  int m_idx = 0, m_pc = 0, m_dc = 0;
  bit m_byp = 1'b0;
  int d_seen = 0, p_seen = 0, eof_seen = 0, sync_seen = 0;
  int s_d_seen = 0, s_p_seen = 0, s_eof_seen = 0;
  int cyc = 0, p_hold_end = 0;
  bit toggle_d = 1'b0, rdy_zero = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_accept(input logic [15:0] v, input bit sof);
    bit pil;
    if (sof && m_idx != 0) begin
      m_idx = 0; m_pc = 0; m_dc = 0;
    end
    pil = !m_byp && ((m_idx % SP) == OFF);
    if (pil) begin
      pq.push_back({12'h0, v, m_pc[3:0]});
      m_pc++;
    end else begin
      dq.push_back({14'h0, v, (m_dc == 0), (m_dc == (m_byp ? FL - 1 : DL - 1))});
      m_dc++;
    end
    if (m_idx == FL - 1) begin
      m_idx = 0; m_pc = 0; m_dc = 0;
      m_byp = bypass;
    end else begin
      m_idx++;
    end
  endtask

  task automatic tick();
    @(posedge clk1);
    #1;
    cyc++;
    d_ready = rdy_zero ? 1'b0 : (toggle_d ? ((cyc % 3) == 0) : 1'b1);
    p_ready = rdy_zero ? 1'b0 : (cyc >= p_hold_end);
  endtask

  task automatic send(input logic [15:0] v, input bit sof);
    bit done = 1'b0;
    in_data = v; in_sof = sof; in_valid = 1'b1;
    for (int t = 0; t < 2000 && !done; t++) begin
      @(negedge clk1);
      if (in_ready) begin
        model_accept(v, sof);
        done = 1'b1;
      end
      tick();
    end
    in_valid = 1'b0; in_sof = 1'b0;
    if (!done) chk("send_timeout", 32'(done), 32'd1);
  endtask

  always @(negedge clk1) begin
    if (rst_n) begin
      if (d_valid && d_ready) begin
        d_seen++;
        if (d_eof) eof_seen++;
        if (dq.size() == 0) chk("d_extra", 32'(dq.size()), 32'd1);
        else chk("d_stream", {14'h0, d_data, d_sof, d_eof}, dq.pop_front());
      end
      if (p_valid && p_ready) begin
        p_seen++;
        if (pq.size() == 0) chk("p_extra", 32'(pq.size()), 32'd1);
        else chk("p_stream", {12'h0, p_data, p_idx}, pq.pop_front());
      end
      if (sync_err) sync_seen++;
      if (s_d_valid && s_d_ready) begin
        s_d_seen++;
        if (s_d_eof) s_eof_seen++;
        if (sdq.size() == 0) chk("s_d_extra", 32'(sdq.size()), 32'd1);
        else chk("s_d_stream", {22'h0, s_d_data, s_d_sof, s_d_eof}, sdq.pop_front());
      end
      if (s_p_valid && s_p_ready) begin
        s_p_seen++;
        if (spq.size() == 0) chk("s_p_extra", 32'(spq.size()), 32'd1);
        else chk("s_p_stream", {21'h0, s_p_data, s_p_idx}, spq.pop_front());
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int sdc, spc;
    bit ok;
    rst_n = 1'b0; bypass = 1'b0; in_valid = 1'b0; in_sof = 1'b0; in_data = '0;
    d_ready = 1'b1; p_ready = 1'b1;
    s_bypass = 1'b0; s_in_valid = 1'b0; s_in_sof = 1'b0; s_in_data = '0;
    s_d_ready = 1'b1; s_p_ready = 1'b1;
    repeat (3) @(posedge clk1);
    #1;
    chk("rst_flags", 32'({d_valid, p_valid, d_sof, d_eof, sync_err}), 32'd0);
    chk("rst_data", {d_data, p_data}, 32'd0);
    chk("rst_pidx", 32'(p_idx), 32'd0);
    chk("rst_cnts", {8'h0, err_cnt, frame_cnt}, 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    tick();

    // Plain frame, both readies high
    for (int i = 0; i < FL; i++) send(16'(i), i == 0);
    repeat (5) tick();
    chk("a_frame_cnt", 32'(frame_cnt), 32'd1);
    chk("a_queues", 32'(dq.size() + pq.size()), 32'd0);
    chk("a_d_seen", 32'(d_seen), 32'd400);
    chk("a_p_seen", 32'(p_seen), 32'd10);
    chk("a_eof_seen", 32'(eof_seen), 32'd1);

    // Backpressure: d_ready 1-of-3, p_ready held low so the pilot slot at idx 41 stalls
    toggle_d = 1'b1;
    p_hold_end = cyc + 220;
    tick();
    for (int i = 0; i < 41; i++) send(16'(i), i == 0);
    @(negedge clk1);
    chk("b_stall_idx41", 32'({in_ready, p_valid}), 32'b01);
    for (int i = 41; i < FL; i++) send(16'(i), 1'b0);
    toggle_d = 1'b0;
    repeat (10) tick();
    chk("b_frame_cnt", 32'(frame_cnt), 32'd2);
    chk("b_queues", 32'(dq.size() + pq.size()), 32'd0);
    chk("b_d_seen", 32'(d_seen), 32'd800);
    chk("b_p_seen", 32'(p_seen), 32'd20);
    chk("b_eof_seen", 32'(eof_seen), 32'd2);

    // Mid-frame SOF at idx 200, then a full frame from there
    for (int i = 0; i < 200; i++) send(16'(i), i == 0);
    for (int i = 0; i < FL; i++) send(16'(1000 + i), i == 0);
    repeat (5) tick();
    chk("c_sync_pulses", 32'(sync_seen), 32'd1);
    chk("c_sync_low", 32'(sync_err), 32'd0);
    chk("c_err_cnt", 32'(err_cnt), 32'd1);
    chk("c_frame_cnt", 32'(frame_cnt), 32'd3);
    chk("c_eof_seen", 32'(eof_seen), 32'd3);
    chk("c_d_seen", 32'(d_seen), 32'd1395);
    chk("c_p_seen", 32'(p_seen), 32'd35);
    chk("c_queues", 32'(dq.size() + pq.size()), 32'd0);

    // Bypass raised mid-frame applies from the following frame only
    for (int i = 0; i < FL; i++) begin
      if (i == 205) bypass = 1'b1;
      send(16'(i), i == 0);
    end
    repeat (3) tick();
    chk("d_p_seen", 32'(p_seen), 32'd45);
    for (int i = 0; i < FL; i++) begin
      if (i == 300) bypass = 1'b0;
      send(16'(2000 + i), i == 0);
    end
    repeat (5) tick();
    chk("e_p_seen", 32'(p_seen), 32'd45);
    chk("e_d_seen", 32'(d_seen), 32'd2205);
    chk("e_eof_seen", 32'(eof_seen), 32'd5);
    chk("e_frame_cnt", 32'(frame_cnt), 32'd5);
    chk("e_queues", 32'(dq.size() + pq.size()), 32'd0);

    // Reset with both holding registers full
    rdy_zero = 1'b1;
    tick();
    send(16'h0AA0, 1'b1);
    send(16'h0AA1, 1'b0);
    repeat (2) tick();
    chk("r_full", 32'({d_valid, p_valid}), 32'b11);
    #2;
    rst_n = 1'b0;
    #1;
    chk("r_valids_drop", 32'({d_valid, p_valid}), 32'b00);
    chk("r_cnts", {8'h0, err_cnt, frame_cnt}, 32'd0);
    dq.delete(); pq.delete();
    m_idx = 0; m_pc = 0; m_dc = 0; m_byp = 1'b0;
    rdy_zero = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < FL; i++) send(16'(3000 + i), 1'b0);
    repeat (5) tick();
    chk("r_frame_cnt", 32'(frame_cnt), 32'd1);
    chk("r_eof_seen", 32'(eof_seen), 32'd6);
    chk("r_queues", 32'(dq.size() + pq.size()), 32'd0);

    // Small geometry: 64 symbols, pilots every 8 at offset 3
    sdc = 0; spc = 0;
    for (int i = 0; i < 64; i++) begin
      s_in_data = 8'(i); s_in_sof = (i == 0); s_in_valid = 1'b1;
      ok = 1'b0;
      for (int t = 0; t < 100 && !ok; t++) begin
        @(negedge clk1);
        if (s_in_ready) begin
          ok = 1'b1;
          if ((i % 8) == 3) begin
            spq.push_back({21'h0, 8'(i), 3'(spc)});
            spc++;
          end else begin
            sdq.push_back({22'h0, 8'(i), (sdc == 0), (sdc == 55)});
            sdc++;
          end
        end
        @(posedge clk1);
        #1;
      end
      if (!ok) chk("s_send_timeout", 32'(ok), 32'd1);
    end
    s_in_valid = 1'b0; s_in_sof = 1'b0;
    repeat (5) tick();
    chk("s_frame_cnt", 32'(s_frame_cnt), 32'd1);
    chk("s_d_seen", 32'(s_d_seen), 32'd56);
    chk("s_p_seen", 32'(s_p_seen), 32'd8);
    chk("s_eof_seen", 32'(s_eof_seen), 32'd1);
    chk("s_queues", 32'(sdq.size() + spq.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
